// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between fetch and data requesters (define ARB_ROUND_RR_EN for round-robin ties)
module unified_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [MASK_W-1:0] d_req_wmask,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_we,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_wdata,
  output logic [MASK_W-1:0] m_req_wmask,
  input  logic              m_rsp_valid,
  output logic              m_rsp_ready,
  input  logic [DATA_W-1:0] m_rsp_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_n;
  logic owner, last_grant, tie_d, grant_d, grant_f;
  logic [DATA_W-1:0] rdata;
`ifdef ARB_ROUND_RR_EN
  assign tie_d = ~last_grant;
`else
  assign tie_d = 1'b1 | last_grant;
`endif
  assign grant_d = d_req_valid & (~f_req_valid | tie_d);
  assign grant_f = f_req_valid & ~grant_d;
  assign busy = state != IDLE;
  assign f_rsp_data = rdata;
  assign d_rsp_data = rdata;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state and handshake strobes
  always_comb begin
    state_n = state;
    f_req_ready = 1'b0;
    d_req_ready = 1'b0;
    m_req_valid = 1'b0;
    m_rsp_ready = 1'b0;
    f_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        f_req_ready = grant_f;
        d_req_ready = grant_d;
        state_n = (grant_f | grant_d) ? REQ : IDLE;
      end
      REQ: begin
        m_req_valid = 1'b1;
        state_n = m_req_ready ? RESP : REQ;
      end
      RESP: begin
        m_rsp_ready = 1'b1;
        state_n = m_rsp_valid ? DONE : RESP;
      end
      default: begin
        f_rsp_valid = ~owner;
        d_rsp_valid = owner;
        state_n = IDLE;
      end
    endcase
  end
  // request fields captured at accept, reply data captured in RESP, grant history updated in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      last_grant <= 1'b0;
      m_req_we <= 1'b0;
      m_req_addr <= '0;
      m_req_wdata <= '0;
      m_req_wmask <= '0;
      rdata <= '0;
    end else begin
      if (state == IDLE && (grant_f | grant_d)) begin
        owner <= grant_d;
        m_req_we <= grant_d & d_req_we;
        m_req_addr <= grant_d ? d_req_addr : f_req_addr;
        m_req_wdata <= grant_d ? d_req_wdata : '0;
        m_req_wmask <= grant_d ? d_req_wmask : '0;
      end
      if (state == RESP && m_rsp_valid) rdata <= m_req_we ? '0 : m_rsp_data;
      if (state == DONE) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized scoreboard bench with a byte-mask memory reference model
module tb_unified_mem_arbiter;
  logic clk = 0, rst = 1;
  logic f_req_valid = 0, f_req_ready, f_rsp_valid;
  logic [63:0] f_req_addr = 0, f_rsp_data;
  logic d_req_valid = 0, d_req_we = 0, d_req_ready, d_rsp_valid;
  logic [63:0] d_req_addr = 0, d_req_wdata = 0, d_rsp_data;
  logic [7:0] d_req_wmask = 0;
  logic m_req_valid, m_req_ready = 0, m_req_we, m_rsp_valid = 0, m_rsp_ready, busy;
  logic [63:0] m_req_addr, m_req_wdata, m_rsp_data = 0;
  logic [7:0] m_req_wmask;

`ifdef ARB_ROUND_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .busy(busy)
  );

  typedef struct { logic own; logic [63:0] data; longint t; } rsp_t;
  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask; } req_t;

  int checks = 0, errors = 0, waits = 0;
  longint cyc = 0;
  rsp_t exp_q[$];
  req_t req_q[$];
  logic grants[$];
  logic model_last = 0;
  logic [63:0] mem[logic [63:0]];
  logic [63:0] ref_mem[logic [63:0]];
  logic pend = 0, p_we = 0, rnd = 0, hold = 0, rsp_hold = 0;
  logic [63:0] p_addr = 0;
  logic dw;
  logic [63:0] ea, ed;
  rsp_t er;
  req_t rq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // downstream memory drive: handshake strobes and reply data
  always @(posedge clk) begin
    #1;
    m_req_ready = rnd ? ($urandom_range(0, 2) != 0) : !hold;
    m_rsp_valid = rnd ? ($urandom_range(0, 2) != 0) : !rsp_hold;
    m_rsp_data = (pend && !p_we) ? mem_rd(p_addr) : {$urandom, $urandom};
  end

  // monitor: memory capture, arbitration model, request/response scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      req_q.delete();
      model_last = 0;
      pend = 0;
      waits = 0;
    end else begin
      if (busy) check("no_accept_while_busy", {62'b0, f_req_ready, d_req_ready}, 64'd0);
      if (f_req_ready || d_req_ready) begin
        check("single_grant", f_req_ready & d_req_ready, 64'd0);
        dw = d_req_ready;
        if (f_req_valid && d_req_valid) check("arb_winner", dw, RR ? !model_last : 1'b1);
        grants.push_back(dw);
        ea = dw ? d_req_addr : f_req_addr;
        if (dw && d_req_we) begin
          ref_mem[ea] = merge(ref_rd(ea), d_req_wdata, d_req_wmask);
          ed = 0;
        end else ed = ref_rd(ea);
        rq.we = dw & d_req_we; rq.addr = ea; rq.wdata = d_req_wdata; rq.wmask = d_req_wmask;
        req_q.push_back(rq);
        er.own = dw; er.data = ed; er.t = cyc;
        exp_q.push_back(er);
        waits = 0;
      end
      if (m_req_valid) begin
        check("m_req_expected", req_q.size() != 0, 64'd1);
        if (req_q.size() != 0) begin
          check("m_req_we", m_req_we, req_q[0].we);
          check("m_req_addr", m_req_addr, req_q[0].addr);
          if (req_q[0].we) begin
            check("m_req_wdata", m_req_wdata, req_q[0].wdata);
            check("m_req_wmask", m_req_wmask, req_q[0].wmask);
          end
        end
        if (m_req_ready) begin
          if (req_q.size() != 0) req_q.delete(0);
          pend = 1; p_we = m_req_we; p_addr = m_req_addr;
          if (m_req_we) mem[m_req_addr] = merge(mem_rd(m_req_addr), m_req_wdata, m_req_wmask);
        end else waits++;
      end
      if (m_rsp_ready) begin
        if (m_rsp_valid) pend = 0;
        else waits++;
      end
      if (f_rsp_valid || d_rsp_valid) begin
        check("one_rsp", f_rsp_valid & d_rsp_valid, 64'd0);
        check("rsp_expected", exp_q.size() != 0, 64'd1);
        if (exp_q.size() != 0) begin
          er = exp_q[0];
          exp_q.delete(0);
          check("rsp_owner", d_rsp_valid, er.own);
          check("rsp_data", d_rsp_valid ? d_rsp_data : f_rsp_data, er.data);
          check("rsp_latency", cyc - er.t, 64'(3 + waits));
          model_last = er.own;
        end
      end
    end
  end

  task automatic do_f(input logic [63:0] a);
    int n = 0;
    @(posedge clk); #1;
    f_req_valid = 1; f_req_addr = a;
    do begin @(negedge clk); n++; end while (!f_req_ready && n < 1000);
    if (!f_req_ready) check("f_accept_timeout", f_req_ready, 64'd1);
    @(posedge clk); #1;
    f_req_valid = 0;
  endtask

  task automatic do_d(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] m);
    int n = 0;
    @(posedge clk); #1;
    d_req_valid = 1; d_req_we = we; d_req_addr = a; d_req_wdata = wd; d_req_wmask = m;
    do begin @(negedge clk); n++; end while (!d_req_ready && n < 1000);
    if (!d_req_ready) check("d_accept_timeout", d_req_ready, 64'd1);
    @(posedge clk); #1;
    d_req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || f_req_valid || d_req_valid) && n < 2000);
    check("idle_reached", busy, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_strobes", {56'b0, f_req_ready, f_rsp_valid, d_req_ready, d_rsp_valid, m_req_valid, m_rsp_ready, busy, m_req_we}, 64'd0);
    check("reset_rsp_data", f_rsp_data | d_rsp_data, 64'd0);
    check("reset_m_fields", m_req_addr | m_req_wdata | {56'b0, m_req_wmask}, 64'd0);

    grants.delete();
    fork
      repeat (3) do_f(64'h3000);
      repeat (3) do_d(1'b0, 64'h3008, 64'd0, 8'd0);
    join
    wait_idle();
    check("tie_grant0", grants[0], 64'd1);
    check("tie_grant1", grants[1], RR ? 64'd0 : 64'd1);
    check("tie_grant2", grants[2], 64'd1);

    mem[64'h1000] = 64'hDEAD_BEEF_0000_0013;
    ref_mem[64'h1000] = 64'hDEAD_BEEF_0000_0013;
    do_reset();
    do_f(64'h1000);
    @(negedge clk);
    check("fetch_mreq_c1", m_req_valid, 64'd1);
    check("fetch_mreq_addr", m_req_addr, 64'h1000);
    repeat (2) @(negedge clk);
    check("fetch_rsp_c3", f_rsp_valid, 64'd1);
    check("fetch_rsp_data", f_rsp_data, 64'hDEAD_BEEF_0000_0013);
    wait_idle();

    do_d(1'b1, 64'h2008, 64'h1122334455667788, 8'h0F);
    @(negedge clk);
    check("write_mreq_we", m_req_we, 64'd1);
    check("write_mreq_wmask", m_req_wmask, 64'h0F);
    check("write_mreq_wdata", m_req_wdata, 64'h1122334455667788);
    repeat (2) @(negedge clk);
    check("write_ack_c3", d_rsp_valid, 64'd1);
    check("write_ack_data", d_rsp_data, 64'd0);
    wait_idle();

    hold = 1;
    do_f(64'h1010);
    fork
      do_d(1'b0, 64'h2008, 64'd0, 8'd0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("hold_mreq_valid", m_req_valid, 64'd1);
          check("hold_mreq_addr", m_req_addr, 64'h1010);
          check("hold_no_second_accept", d_req_ready, 64'd0);
        end
        hold = 0;
      end
    join
    wait_idle();

    rsp_hold = 1;
    do_f(64'h1018);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!m_rsp_ready && n < 50);
    end
    check("reached_resp", m_rsp_ready, 64'd1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    rsp_hold = 0;
    repeat (4) begin
      @(negedge clk);
      check("rst_busy", busy, 64'd0);
      check("rst_no_pulse", f_rsp_valid | d_rsp_valid, 64'd0);
    end
    do_f(64'h1000);
    wait_idle();
    check("fresh_fetch_done", exp_q.size(), 64'd0);

    rnd = 1;
    fork
      repeat (80) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_f(64'h1000 + 64'($urandom_range(0, 7)) * 8);
      end
      repeat (80) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_d(1'($urandom_range(0, 1)), 64'h1000 + 64'($urandom_range(0, 7)) * 8, {$urandom, $urandom}, 8'($urandom));
      end
    join
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
